// File: rtl/iob_iob2axi_dma_pkg.sv
// Shared AXI constants and FSM encoding for the IOb-native to AXI4 DMA bridge.
package iob_iob2axi_dma_pkg;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
  localparam logic [2:0] PROT_DEFAULT  = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WADDR,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA,
    ST_DONE
  } state_t;

  // AXI size encoding of one full data word: log2(bytes per beat).
  function automatic logic [2:0] axi_size(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/iob_iob2axi_dma_if.sv
// AXI4 full bus between the DMA bridge (master) and memory/interconnect (slave).
interface iob_iob2axi_dma_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32,
  parameter int ID_W   = 1,
  parameter int LEN_W  = 8
);
  logic [ID_W-1:0]     m_axi_awid;
  logic [ADDR_W-1:0]   m_axi_awaddr;
  logic [LEN_W-1:0]    m_axi_awlen;
  logic [2:0]          m_axi_awsize;
  logic [1:0]          m_axi_awburst;
  logic                m_axi_awlock;
  logic [3:0]          m_axi_awcache;
  logic [2:0]          m_axi_awprot;
  logic                m_axi_awvalid;
  logic                m_axi_awready;
  logic [DATA_W-1:0]   m_axi_wdata;
  logic [DATA_W/8-1:0] m_axi_wstrb;
  logic                m_axi_wlast;
  logic                m_axi_wvalid;
  logic                m_axi_wready;
  logic [ID_W-1:0]     m_axi_bid;
  logic [1:0]          m_axi_bresp;
  logic                m_axi_bvalid;
  logic                m_axi_bready;
  logic [ID_W-1:0]     m_axi_arid;
  logic [ADDR_W-1:0]   m_axi_araddr;
  logic [LEN_W-1:0]    m_axi_arlen;
  logic [2:0]          m_axi_arsize;
  logic [1:0]          m_axi_arburst;
  logic                m_axi_arlock;
  logic [3:0]          m_axi_arcache;
  logic [2:0]          m_axi_arprot;
  logic                m_axi_arvalid;
  logic                m_axi_arready;
  logic [ID_W-1:0]     m_axi_rid;
  logic [DATA_W-1:0]   m_axi_rdata;
  logic [1:0]          m_axi_rresp;
  logic                m_axi_rlast;
  logic                m_axi_rvalid;
  logic                m_axi_rready;

  modport master (
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
           m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
           m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready,
           m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid, m_axi_rready,
    input  m_axi_awready, m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid,
           m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
           m_axi_rvalid
  );

  modport slave (
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
           m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
           m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready,
           m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid, m_axi_rready,
    output m_axi_awready, m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid,
           m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
           m_axi_rvalid
  );
endinterface

// File: rtl/iob_iob2axi_dma.sv
// IOb native slave to AXI4 master bridge: each native request becomes one
// single-beat AXI read or write at base + word_offset * bytes_per_word.
module iob_iob2axi_dma
  import iob_iob2axi_dma_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 32,
  parameter int AXI_ADDR_W = ADDR_W,
  parameter int AXI_DATA_W = DATA_W,
  parameter int AXI_ID_W   = 1,
  parameter int AXI_LEN_W  = 8
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                run_i,
  input  logic                direction_i,
  input  logic [ADDR_W-1:0]   addr_i,
  output logic                ready_o,
  output logic                error_o,
  input  logic                s_valid_i,
  input  logic [ADDR_W-1:0]   s_addr_i,
  input  logic [DATA_W-1:0]   s_wdata_i,
  input  logic [DATA_W/8-1:0] s_wstrb_i,
  output logic [DATA_W-1:0]   s_rdata_o,
  output logic                s_ready_o,
  iob_iob2axi_dma_if.master   axi
);

  localparam logic [2:0] SIZE = axi_size(AXI_DATA_W);

  state_t state, state_nxt;
  logic              dir_q, dir_nxt;
  logic [ADDR_W-1:0] base_q, base_nxt;
  logic              ready_nxt, error_nxt, s_ready_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic              awvalid_q, awvalid_nxt, wvalid_q, wvalid_nxt, bready_q, bready_nxt;
  logic              arvalid_q, arvalid_nxt, rready_q, rready_nxt;
  logic              load_req;

  logic [AXI_ADDR_W-1:0] req_addr, addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wstrb_q;

  // Address arithmetic wraps silently at the AXI address width.
  assign req_addr = AXI_ADDR_W'(base_q) + (AXI_ADDR_W'(s_addr_i) << SIZE);

  always_comb begin
    state_nxt   = state;
    dir_nxt     = dir_q;
    base_nxt    = base_q;
    error_nxt   = error_o;
    s_ready_nxt = s_ready_o;
    rdata_nxt   = s_rdata_o;
    awvalid_nxt = awvalid_q;
    wvalid_nxt  = wvalid_q;
    bready_nxt  = bready_q;
    arvalid_nxt = arvalid_q;
    rready_nxt  = rready_q;
    load_req    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run_i && !s_valid_i) begin
          base_nxt  = addr_i;
          dir_nxt   = direction_i;
          error_nxt = 1'b0;
        end else if (s_valid_i && !s_ready_o) begin
          load_req = 1'b1;
          if (dir_q) begin
            state_nxt   = ST_WADDR;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
          end else begin
            state_nxt   = ST_RADDR;
            arvalid_nxt = 1'b1;
          end
        end
      end
      ST_WADDR: begin
        if (axi.m_axi_awready) awvalid_nxt = 1'b0;
        if (axi.m_axi_wready)  wvalid_nxt  = 1'b0;
        // AW and W complete independently; wait until both have been accepted.
        if ((!awvalid_q || axi.m_axi_awready) && (!wvalid_q || axi.m_axi_wready)) begin
          state_nxt  = ST_WRESP;
          bready_nxt = 1'b1;
        end
      end
      ST_WRESP: begin
        if (axi.m_axi_bvalid) begin
          state_nxt   = ST_DONE;
          bready_nxt  = 1'b0;
          s_ready_nxt = 1'b1;
          if (axi.m_axi_bresp != RESP_OKAY) error_nxt = 1'b1;
        end
      end
      ST_RADDR: begin
        if (axi.m_axi_arready) begin
          state_nxt   = ST_RDATA;
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
        end
      end
      ST_RDATA: begin
        if (axi.m_axi_rvalid) begin
          state_nxt   = ST_DONE;
          rready_nxt  = 1'b0;
          s_ready_nxt = 1'b1;
          rdata_nxt   = axi.m_axi_rdata;
          if (axi.m_axi_rresp != RESP_OKAY) error_nxt = 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt   = ST_IDLE;
        s_ready_nxt = 1'b0;
      end
      default: state_nxt = ST_IDLE;
    endcase
    ready_nxt = (state_nxt == ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state     <= ST_IDLE;
      dir_q     <= 1'b0;
      base_q    <= '0;
      ready_o   <= 1'b1;
      error_o   <= 1'b0;
      s_ready_o <= 1'b0;
      s_rdata_o <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      dir_q     <= dir_nxt;
      base_q    <= base_nxt;
      ready_o   <= ready_nxt;
      error_o   <= error_nxt;
      s_ready_o <= s_ready_nxt;
      s_rdata_o <= rdata_nxt;
      awvalid_q <= awvalid_nxt;
      wvalid_q  <= wvalid_nxt;
      bready_q  <= bready_nxt;
      arvalid_q <= arvalid_nxt;
      rready_q  <= rready_nxt;
    end
  end

  // Payload only changes when leaving IDLE, so it is stable under every valid.
  always_ff @(posedge clk_i) begin
    if (load_req) begin
      addr_q  <= req_addr;
      wdata_q <= s_wdata_i;
      wstrb_q <= s_wstrb_i;
    end
  end

  assign axi.m_axi_awid    = AXI_ID_W'(0);
  assign axi.m_axi_awaddr  = addr_q;
  assign axi.m_axi_awlen   = AXI_LEN_W'(0);
  assign axi.m_axi_awsize  = SIZE;
  assign axi.m_axi_awburst = BURST_INCR;
  assign axi.m_axi_awlock  = 1'b0;
  assign axi.m_axi_awcache = CACHE_DEFAULT;
  assign axi.m_axi_awprot  = PROT_DEFAULT;
  assign axi.m_axi_awvalid = awvalid_q;
  assign axi.m_axi_wdata   = wdata_q;
  assign axi.m_axi_wstrb   = wstrb_q;
  assign axi.m_axi_wlast   = 1'b1;
  assign axi.m_axi_wvalid  = wvalid_q;
  assign axi.m_axi_bready  = bready_q;
  assign axi.m_axi_arid    = AXI_ID_W'(0);
  assign axi.m_axi_araddr  = addr_q;
  assign axi.m_axi_arlen   = AXI_LEN_W'(0);
  assign axi.m_axi_arsize  = SIZE;
  assign axi.m_axi_arburst = BURST_INCR;
  assign axi.m_axi_arlock  = 1'b0;
  assign axi.m_axi_arcache = CACHE_DEFAULT;
  assign axi.m_axi_arprot  = PROT_DEFAULT;
  assign axi.m_axi_arvalid = arvalid_q;
  assign axi.m_axi_rready  = rready_q;

  logic unused_axi;
  assign unused_axi = ^{axi.m_axi_bid, axi.m_axi_rid, axi.m_axi_rlast};

endmodule

// File: tb/tb_iob_iob2axi_dma.sv
// Directed bench for iob_iob2axi_dma with an embedded single-beat AXI memory slave.
module tb_iob_iob2axi_dma;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0, dir = 1'b0;
  logic [23:0] base = '0;
  logic        ready, error;
  logic        s_valid = 1'b0;
  logic [23:0] s_addr = '0;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic [31:0] s_rdata;
  logic        s_ready;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  iob_iob2axi_dma_if #(.ADDR_W(24), .DATA_W(32), .ID_W(1), .LEN_W(8)) axi ();

  iob_iob2axi_dma #(
    .ADDR_W(24), .DATA_W(32), .AXI_ADDR_W(24), .AXI_DATA_W(32), .AXI_ID_W(1), .AXI_LEN_W(8)
  ) dut (
    .clk_i(clk), .arst_n_i(rst_n), .run_i(run), .direction_i(dir), .addr_i(base),
    .ready_o(ready), .error_o(error), .s_valid_i(s_valid), .s_addr_i(s_addr),
    .s_wdata_i(s_wdata), .s_wstrb_i(s_wstrb), .s_rdata_o(s_rdata), .s_ready_o(s_ready),
    .axi(axi)
  );

  // ---------------- AXI memory slave model ----------------
  logic [31:0] mem [0:16383];
  int          aw_dly = 0, w_dly = 0, aw_cnt, w_cnt;
  int          aw_hs = 0, w_hs = 0, ar_hs = 0;
  logic        aw_got, w_got, bvalid_r, rvalid_r;
  logic [23:0] aw_a, wa;
  logic [31:0] w_d, wd, rdata_r, merged;
  logic [3:0]  w_s, ws;
  logic [1:0]  bresp_r;
  logic        err_en = 1'b0;
  logic [23:0] err_addr = '0;
  logic        awready_w, wready_w, arready_w, wr_fire;

  assign awready_w = axi.m_axi_awvalid && (aw_cnt >= aw_dly);
  assign wready_w  = axi.m_axi_wvalid && (w_cnt >= w_dly);
  assign arready_w = axi.m_axi_arvalid;
  assign wa = aw_got ? aw_a : axi.m_axi_awaddr;
  assign wd = w_got ? w_d : axi.m_axi_wdata;
  assign ws = w_got ? w_s : axi.m_axi_wstrb;
  assign wr_fire = (aw_got || awready_w) && (w_got || wready_w) && !bvalid_r;

  always_comb begin
    merged = mem[wa[15:2]];
    for (int b = 0; b < 4; b++)
      if (ws[b]) merged[8*b +: 8] = wd[8*b +: 8];
  end

  assign axi.m_axi_awready = awready_w;
  assign axi.m_axi_wready  = wready_w;
  assign axi.m_axi_arready = arready_w;
  assign axi.m_axi_bid     = 1'b0;
  assign axi.m_axi_bresp   = bresp_r;
  assign axi.m_axi_bvalid  = bvalid_r;
  assign axi.m_axi_rid     = 1'b0;
  assign axi.m_axi_rdata   = rdata_r;
  assign axi.m_axi_rresp   = 2'b00;
  assign axi.m_axi_rlast   = 1'b1;
  assign axi.m_axi_rvalid  = rvalid_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      bvalid_r <= 1'b0; bresp_r <= 2'b00; rvalid_r <= 1'b0; rdata_r <= '0;
    end else begin
      aw_cnt <= (axi.m_axi_awvalid && !awready_w) ? aw_cnt + 1 : 0;
      w_cnt  <= (axi.m_axi_wvalid && !wready_w) ? w_cnt + 1 : 0;
      if (awready_w) aw_hs <= aw_hs + 1;
      if (wready_w)  w_hs <= w_hs + 1;
      if (bvalid_r && axi.m_axi_bready) bvalid_r <= 1'b0;
      if (wr_fire) begin
        mem[wa[15:2]] <= merged;
        bvalid_r <= 1'b1;
        bresp_r  <= (err_en && wa == err_addr) ? 2'b10 : 2'b00;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (awready_w) begin aw_got <= 1'b1; aw_a <= axi.m_axi_awaddr; end
        if (wready_w) begin w_got <= 1'b1; w_d <= axi.m_axi_wdata; w_s <= axi.m_axi_wstrb; end
      end
      if (arready_w) begin
        rvalid_r <= 1'b1;
        rdata_r  <= mem[axi.m_axi_araddr[15:2]];
        ar_hs    <= ar_hs + 1;
      end else if (rvalid_r && axi.m_axi_rready) begin
        rvalid_r <= 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic        obs_awv1, obs_arv1, obs_ok, obs_err;
  logic [23:0] obs_addr1;
  logic [31:0] obs_rdata;
  logic [22:0] obs_awf;
  logic [21:0] obs_arf;
  int          obs_lat;

  task automatic do_run(input logic d, input logic [23:0] a);
    @(negedge clk);
    run = 1'b1; dir = d; base = a;
    @(negedge clk);
    run = 1'b0;
  endtask

  // One native request; records what the AXI side shows one cycle after s_valid.
  task automatic req(input logic [23:0] a, input logic [31:0] d, input logic [3:0] st);
    @(negedge clk);
    s_addr = a; s_wdata = d; s_wstrb = st; s_valid = 1'b1;
    @(negedge clk);
    obs_lat   = 1;
    obs_awv1  = axi.m_axi_awvalid;
    obs_arv1  = axi.m_axi_arvalid;
    obs_addr1 = axi.m_axi_awvalid ? axi.m_axi_awaddr : axi.m_axi_araddr;
    obs_awf   = {axi.m_axi_awid, axi.m_axi_awlen, axi.m_axi_awsize, axi.m_axi_awburst,
                 axi.m_axi_awlock, axi.m_axi_awcache, axi.m_axi_awprot, axi.m_axi_wlast};
    obs_arf   = {axi.m_axi_arid, axi.m_axi_arlen, axi.m_axi_arsize, axi.m_axi_arburst,
                 axi.m_axi_arlock, axi.m_axi_arcache, axi.m_axi_arprot};
    while (!s_ready && obs_lat < 64) begin
      @(negedge clk);
      obs_lat++;
    end
    obs_ok    = s_ready;
    obs_rdata = s_rdata;
    obs_err   = error;
    s_valid   = 1'b0;
    if (!obs_ok) begin
      total++; bad++;
      $display("FAIL req_timeout addr=%h s_ready=%b required=1 within 64 cycles", a, s_ready);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", ready); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL rst_error got=%b want=0", error); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready got=%b want=0", s_ready); end
    total++; if (s_rdata !== 32'h0) begin bad++; $display("FAIL rst_s_rdata got=%h want=0", s_rdata); end
    total++;
    if ({axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_bready, axi.m_axi_arvalid, axi.m_axi_rready} !== 5'b0) begin
      bad++;
      $display("FAIL rst_axi_ctrl got=%b want=00000", {axi.m_axi_awvalid, axi.m_axi_wvalid,
               axi.m_axi_bready, axi.m_axi_arvalid, axi.m_axi_rready});
    end
  endtask

  task automatic test_latency();
    logic [22:0] exp_awf;
    logic [21:0] exp_arf;
    exp_awf = {1'b0, 8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b010, 1'b1};
    exp_arf = {1'b0, 8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b010};
    do_run(1'b1, 24'h000100);
    req(24'd3, 32'hDEADBEEF, 4'hF);
    total++; if (obs_awv1 !== 1'b1) begin bad++; $display("FAIL lat_awvalid got=%b want=1", obs_awv1); end
    total++; if (obs_addr1 !== 24'h00010C) begin bad++; $display("FAIL lat_awaddr got=%h want=00010c", obs_addr1); end
    total++; if (obs_awf !== exp_awf) begin bad++; $display("FAIL lat_aw_fields got=%h want=%h", obs_awf, exp_awf); end
    total++; if (obs_lat !== 3) begin bad++; $display("FAIL lat_write got=%0d want=3", obs_lat); end
    total++; if (mem[14'h0043] !== 32'hDEADBEEF) begin bad++; $display("FAIL lat_mem got=%h want=deadbeef", mem[14'h0043]); end
    do_run(1'b0, 24'h000100);
    req(24'd3, 32'h0, 4'h0);
    total++; if (obs_arv1 !== 1'b1) begin bad++; $display("FAIL lat_arvalid got=%b want=1", obs_arv1); end
    total++; if (obs_addr1 !== 24'h00010C) begin bad++; $display("FAIL lat_araddr got=%h want=00010c", obs_addr1); end
    total++; if (obs_arf !== exp_arf) begin bad++; $display("FAIL lat_ar_fields got=%h want=%h", obs_arf, exp_arf); end
    total++; if (obs_lat !== 3) begin bad++; $display("FAIL lat_read got=%0d want=3", obs_lat); end
    total++; if (obs_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lat_rdata got=%h want=deadbeef", obs_rdata); end
  endtask

  task automatic test_write_block();
    int lat_sum = 0;
    logic [13:0] wi;
    do_run(1'b1, 24'h007FD8);
    for (int i = 0; i < 1024; i++) begin
      req(24'(i), 32'(i + 32), 4'hF);
      lat_sum += obs_lat;
    end
    total++; if (lat_sum !== 3072) begin bad++; $display("FAIL blk_wr_latency got=%0d want=3072", lat_sum); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL blk_wr_error got=%b want=0", error); end
    for (int i = 0; i < 1024; i++) begin
      wi = 14'((32'h7FD8 + 4 * i) >> 2);
      total++;
      if (mem[wi] !== 32'(i + 32)) begin
        bad++; $display("FAIL blk_wr_mem i=%0d got=%h want=%h", i, mem[wi], 32'(i + 32));
      end
    end
  endtask

  task automatic test_read_block();
    do_run(1'b0, 24'h007FD8);
    for (int i = 0; i < 1024; i++) begin
      req(24'(i), 32'h0, 4'h0);
      total++;
      if (obs_rdata !== 32'(i + 32)) begin
        bad++; $display("FAIL blk_rd_data i=%0d got=%h want=%h", i, obs_rdata, 32'(i + 32));
      end
    end
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL blk_rd_ready got=%b want=1", ready); end
  endtask

  task automatic test_stall();
    int awc = 0, wc = 0, unstable = 0, lat = 0, aw0, w0;
    do_run(1'b1, 24'h000200);
    req(24'd2, 32'h11223344, 4'hF);
    aw_dly = 3; w_dly = 1; aw0 = aw_hs; w0 = w_hs;
    @(negedge clk);
    s_addr = 24'd2; s_wdata = 32'hA5A55A5A; s_wstrb = 4'h3; s_valid = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (axi.m_axi_awvalid) begin
        awc++;
        if (axi.m_axi_awaddr !== 24'h000208) unstable++;
      end
      if (axi.m_axi_wvalid) begin
        wc++;
        if (axi.m_axi_wdata !== 32'hA5A55A5A || axi.m_axi_wstrb !== 4'h3) unstable++;
      end
    end while (!s_ready && lat < 64);
    s_valid = 1'b0; aw_dly = 0; w_dly = 0;
    total++; if (lat !== 6) begin bad++; $display("FAIL stall_latency got=%0d want=6", lat); end
    total++; if (awc !== 4) begin bad++; $display("FAIL stall_awvalid_cycles got=%0d want=4", awc); end
    total++; if (wc !== 2) begin bad++; $display("FAIL stall_wvalid_cycles got=%0d want=2", wc); end
    total++; if (unstable !== 0) begin bad++; $display("FAIL stall_payload_changes got=%0d want=0", unstable); end
    total++; if (aw_hs - aw0 !== 1) begin bad++; $display("FAIL stall_aw_count got=%0d want=1", aw_hs - aw0); end
    total++; if (w_hs - w0 !== 1) begin bad++; $display("FAIL stall_w_count got=%0d want=1", w_hs - w0); end
    total++; if (mem[14'h0082] !== 32'h11225A5A) begin bad++; $display("FAIL stall_mem got=%h want=11225a5a", mem[14'h0082]); end
  endtask

  task automatic test_error();
    logic exp;
    do_run(1'b1, 24'h001000);
    err_addr = 24'h001014; err_en = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      req(24'(i), 32'(i), 4'hF);
      exp = (i >= 5);
      total++;
      if (obs_err !== exp) begin bad++; $display("FAIL err_sticky word=%0d got=%b want=%b", i, obs_err, exp); end
    end
    err_en = 1'b0;
    do_run(1'b1, 24'h001000);
    total++; if (error !== 1'b0) begin bad++; $display("FAIL err_clear_on_run got=%b want=0", error); end
  endtask

  task automatic test_run_busy();
    logic busy_rdy;
    do_run(1'b1, 24'h002000);
    fork
      req(24'd0, 32'h00000077, 4'hF);
      begin
        repeat (2) @(negedge clk);
        busy_rdy = ready;
        run = 1'b1; dir = 1'b0; base = 24'h003000;
        @(negedge clk);
        run = 1'b0;
      end
    join
    total++; if (busy_rdy !== 1'b0) begin bad++; $display("FAIL busy_ready got=%b want=0", busy_rdy); end
    req(24'd1, 32'h00000088, 4'hF);
    total++; if (obs_awv1 !== 1'b1 || obs_arv1 !== 1'b0) begin
      bad++; $display("FAIL busy_dir aw=%b ar=%b want aw=1 ar=0", obs_awv1, obs_arv1);
    end
    total++; if (obs_addr1 !== 24'h002004) begin bad++; $display("FAIL busy_base got=%h want=002004", obs_addr1); end
  endtask

  task automatic test_wrap();
    do_run(1'b1, 24'hFFFFFC);
    req(24'd1, 32'hCAFEF00D, 4'hF);
    total++; if (obs_addr1 !== 24'h000000) begin bad++; $display("FAIL wrap_awaddr got=%h want=000000", obs_addr1); end
    total++; if (mem[14'h0000] !== 32'hCAFEF00D) begin bad++; $display("FAIL wrap_mem got=%h want=cafef00d", mem[14'h0000]); end
  endtask

  task automatic test_reset_mid();
    do_run(1'b1, 24'h000400);
    @(negedge clk);
    s_addr = 24'd5; s_wdata = 32'h12345678; s_wstrb = 4'hF; s_valid = 1'b1;
    @(negedge clk);
    total++; if (axi.m_axi_awvalid !== 1'b1) begin bad++; $display("FAIL rmid_pre_awvalid got=%b want=1", axi.m_axi_awvalid); end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_bready, axi.m_axi_arvalid, axi.m_axi_rready} !== 5'b0) begin
      bad++;
      $display("FAIL rmid_axi_ctrl got=%b want=00000", {axi.m_axi_awvalid, axi.m_axi_wvalid,
               axi.m_axi_bready, axi.m_axi_arvalid, axi.m_axi_rready});
    end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b want=1", ready); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rmid_s_ready got=%b want=0", s_ready); end
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // Base and direction are back at 0, so the next request is a read at 4*offset.
    req(24'd3, 32'h0, 4'h0);
    total++; if (obs_arv1 !== 1'b1 || obs_awv1 !== 1'b0) begin
      bad++; $display("FAIL rmid_dir ar=%b aw=%b want ar=1 aw=0", obs_arv1, obs_awv1);
    end
    total++; if (obs_addr1 !== 24'h00000C) begin bad++; $display("FAIL rmid_base got=%h want=00000c", obs_addr1); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_write_block();
    test_read_block();
    test_stall();
    test_error();
    test_run_busy();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout time=%0t limit=2000000", $time);
    $fatal(1, "timeout");
  end

endmodule
